sram_arbiter: RTL

- Shares one single-port, 1-cycle-read-latency SRAM block between two requesters.
- Port 0 is the display pixel-fetch path and is read-only. Port 1 is the game/logic path and does reads and writes.
- Uses fixed priority for port 0, a starvation guard for port 1, and an optional bounded burst lock for port 1.
- Sits between the requesters and the sram instance; it drives the en/we/addr/data_i inputs of the sram and routes data_o back.

---
 rtl/sram_arbiter_pkg.sv | 11 +
 rtl/sram_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared definitions for the SRAM arbiter.
//   arb_state_t - arbiter FSM state encoding (ARB / LOCK1 / COOL)
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK1 = 2'd1,
    COOL  = 2'd2
  } arb_state_t;

endpackage : sram_arbiter_pkg

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port, 1-cycle-read-latency SRAM between
// a read-only display fetch port (port 0, fixed priority) and a read/write
// logic port (port 1, starvation guard plus optional bounded burst lock).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req0/addr0 -> gnt0, rvalid0  port-0 read request, grant, read valid
//   req1/we1/lock1/addr1/wdata1  port-1 request, write, lock, address, data
//   gnt1, rvalid1                port-1 grant, read valid (reads only)
//   rdata                        shared read data (direct from sram_rdata)
//   sram_en/we/addr/wdata        SRAM control/address/write data
//   sram_rdata                   SRAM read data
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_WAIT   = 4,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  gnt0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [WW-1:0] WAIT_TOP = WW'(MAX_WAIT);
  localparam logic [LW-1:0] LOCK_TOP = LW'(LOCK_MAX - 1);

  arb_state_t    state;
  logic [WW-1:0] wait_cnt;
  logic [LW-1:0] lock_cnt;

  logic starve;
  logic locked;
  logic arb_gnt0;
  logic arb_gnt1;

  always_comb begin
    starve   = req1 && (wait_cnt == WAIT_TOP);
    arb_gnt1 = req1 && (starve || !req0);
    arb_gnt0 = req0 && !starve;
    // In LOCK1 port 1 owns the SRAM only while it keeps both req1 and lock1
    // high; otherwise the cycle falls back to the normal arbitration rules.
    locked   = (state == LOCK1) && req1 && lock1;
    // reset_n gates the grants so the SRAM sees nothing while in reset.
    gnt1     = reset_n && (locked || arb_gnt1);
    gnt0     = reset_n && !locked && arb_gnt0;
  end

  always_comb begin
    sram_en    = gnt0 | gnt1;
    sram_we    = gnt1 & we1;
    sram_addr  = gnt0 ? addr0 : (gnt1 ? addr1 : '0);
    sram_wdata = gnt1 ? wdata1 : '0;
    rdata      = sram_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB;
      wait_cnt <= '0;
      lock_cnt <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      rvalid0 <= gnt0;
      rvalid1 <= gnt1 && !we1;

      // Port 1 is never denied while locked, so the count only advances
      // outside LOCK1 (a fallback cycle in LOCK1 holds it).
      if (!req1 || gnt1) begin
        wait_cnt <= '0;
      end else if ((state != LOCK1) && (wait_cnt != WAIT_TOP)) begin
        wait_cnt <= wait_cnt + WW'(1);
      end

      unique case (state)
        ARB: begin
          if (gnt1 && lock1) begin
            state    <= LOCK1;
            lock_cnt <= LW'(1);
          end
        end
        LOCK1: begin
          if (locked) begin
            lock_cnt <= lock_cnt + LW'(1);
            if (lock_cnt == LOCK_TOP) begin
              state <= COOL;
            end
          end else begin
            state <= ARB;
          end
        end
        COOL: begin
          state <= ARB;
        end
        default: begin
          state <= ARB;
        end
      endcase
    end
  end

endmodule : sram_arbiter
